// File: rtl/sram_like_mo_handshake.sv
// sram_like_mo_handshake: multi-outstanding SRAM-like master handshake with in-order tag return; optional watchdog via SRAM_HS_TIMEOUT_EN
module sram_like_mo_handshake #(
  parameter int ID_W      = 32,
  parameter int TAG_W     = 4,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [ID_W-1:0]                unique_id,
  input  logic                           force_req,
  input  logic                           need_req,
  input  logic [TAG_W-1:0]               tag_in,
  output logic                           busy,
  output logic                           req,
  input  logic                           addr_ok,
  input  logic                           data_ok,
  output logic                           resp_valid,
  output logic [TAG_W-1:0]               resp_tag,
  output logic [$clog2(MAX_OUTST+1)-1:0] outstanding,
  output logic                           err
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   id_prev;
  logic [TAG_W-1:0]  hold_tag, cur_tag;
  logic [TAG_W-1:0]  fifo [MAX_OUTST];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, cnt_next;
  logic              accept, dq, bypass, push, pop, spurious, timeout_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // request generation: fresh id/force in IDLE, unconditional replay of the held request in HOLD
  always_comb begin
    state_next = state;
    req        = 1'b0;
    cur_tag    = tag_in;
    if (state == HOLD) begin
      req     = 1'b1;
      cur_tag = hold_tag;
      if (addr_ok) state_next = IDLE;
    end else begin
      req = need_req && (unique_id != id_prev || force_req) && (count < CW'(MAX_OUTST));
      if (req && !addr_ok) state_next = HOLD;
    end
  end

  // a response with nothing tracked and nothing being accepted is spurious; zero-latency accept+response bypasses the FIFO
  assign accept      = req && addr_ok;
  assign dq          = data_ok && (count != '0 || accept);
  assign bypass      = data_ok && accept && count == '0;
  assign push        = accept && !bypass;
  assign pop         = dq && !bypass;
  assign spurious    = data_ok && !dq;
  assign cnt_next    = count + CW'(push) - CW'(pop);
  assign resp_valid  = dq;
  assign resp_tag    = bypass ? cur_tag : fifo[rd_ptr];
  assign busy        = (state == IDLE && req && !addr_ok) || state == HOLD || cnt_next != '0;
  assign outstanding = count;

  // handshake state, request identity/tag capture and occupancy tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      id_prev  <= '1;
      hold_tag <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_next;
      count <= cnt_next;
      if (state == IDLE && req) begin
        id_prev  <= unique_id;
        hold_tag <= tag_in;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // tag storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= cur_tag;
  end

`ifdef SRAM_HS_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;

  // watchdog counts stalled cycles while responses are owed, saturating at TIMEOUT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wd <= '0;
    else if (data_ok || count == '0) wd <= '0;
    else if (wd != WW'(TIMEOUT)) wd <= wd + WW'(1);
  end

  assign timeout_hit = count != '0 && !data_ok && wd == WW'(TIMEOUT - 1);
`else
  assign timeout_hit = 1'b0;
`endif

  // sticky error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err <= 1'b0;
    else if (spurious || timeout_hit) err <= 1'b1;
  end
endmodule
